// File: rtl/decode_stage_p.sv
// RISC-V decode stage: register file with write-back forwarding, immediate generation,
// load-use stall, early branch resolution with wrong-path kill, and the ID/EX register.
module decode_stage_p #(
   parameter int XLEN       = 32,
   parameter int NREG       = 32,
   parameter int BYPASS     = 1,
   parameter int KILL_SLOTS = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_wr,
   input  logic [4:0]      i_rd,
   input  logic [XLEN-1:0] i_write_data,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_rs1_data,
   output logic [XLEN-1:0] o_rs2_data,
   output logic [XLEN-1:0] o_imm_data,
   output logic [6:0]      o_opcode,
   output logic [2:0]      o_func3,
   output logic [4:0]      o_rd,
   output logic [XLEN-1:0] o_pc,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_redirect_pc,
   output logic [15:0]     o_stall_cnt
);
   localparam int AW = $clog2(NREG);
   localparam logic [5:0] NREG_L = 6'(NREG);
   localparam logic [1:0] KILL_L = 2'(KILL_SLOTS);
   localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {ST_RUN = 2'd0, ST_KILL = 2'd1, ST_STALL = 2'd2} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] rf_q [NREG];
   logic            valid_q, redirect_q;
   logic [XLEN-1:0] rs1_q, rs2_q, imm_q, pc_q, redirect_pc_q;
   logic [6:0]      opcode_q;
   logic [2:0]      func3_q;
   logic [4:0]      rd_q;
   logic [15:0]     stall_q;
   logic [1:0]      kill_q;

   logic [6:0]      opc_s;
   logic [2:0]      f3_s;
   logic [4:0]      rs1_idx_s, rs2_idx_s;
   logic [XLEN-1:0] rs1_s, rs2_s, imm_s, target_s;
   logic            rs1_used_s, rs2_used_s, hazard_s, ready_s, hs_s, accept_s, taken_s;

   // Forwarding only applies to in-range nonzero indices, so x0 can never be bypassed.
   function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx, input logic [XLEN-1:0] stored,
         input logic wr, input logic [4:0] wr_idx, input logic [XLEN-1:0] wr_data);
      logic [XLEN-1:0] val;
      if (idx == 5'd0 || {1'b0, idx} >= NREG_L) val = '0;
      else if (BYPASS != 0 && wr && wr_idx == idx) val = wr_data;
      else val = stored;
      return val;
   endfunction

   always_comb begin
      opc_s     = i_instr[6:0];
      f3_s      = i_instr[14:12];
      rs1_idx_s = i_instr[19:15];
      rs2_idx_s = i_instr[24:20];
      rs1_s     = read_port(rs1_idx_s, rf_q[rs1_idx_s[AW-1:0]], i_wr, i_rd, i_write_data);
      rs2_s     = read_port(rs2_idx_s, rf_q[rs2_idx_s[AW-1:0]], i_wr, i_rd, i_write_data);
      imm_s     = '0;
      case (opc_s)
         OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_FENCE:
            imm_s = XLEN'($signed(i_instr[31:20]));
         OPC_STORE:
            imm_s = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
         OPC_BRANCH:
            imm_s = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
         OPC_LUI, OPC_AUIPC:
            imm_s = XLEN'($signed({i_instr[31:12], 12'h000}));
         OPC_JAL:
            imm_s = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
         default: imm_s = '0;
      endcase

      taken_s  = 1'b0;
      target_s = i_pc + imm_s;
      case (opc_s)
         OPC_BRANCH: begin
            case (f3_s)
               3'b000:  taken_s = (rs1_s == rs2_s);
               3'b001:  taken_s = (rs1_s != rs2_s);
               3'b100:  taken_s = ($signed(rs1_s) < $signed(rs2_s));
               3'b101:  taken_s = ($signed(rs1_s) >= $signed(rs2_s));
               3'b110:  taken_s = (rs1_s < rs2_s);
               3'b111:  taken_s = (rs1_s >= rs2_s);
               default: taken_s = 1'b0;
            endcase
         end
         OPC_JAL:  taken_s = 1'b1;
         OPC_JALR: begin
            taken_s  = 1'b1;
            target_s = (rs1_s + imm_s) & JALR_MASK;
         end
         default: taken_s = 1'b0;
      endcase

      rs1_used_s = !(opc_s == OPC_LUI || opc_s == OPC_AUIPC || opc_s == OPC_JAL);
      rs2_used_s = (opc_s == OPC_OP || opc_s == OPC_STORE || opc_s == OPC_BRANCH);
      hazard_s   = i_valid && valid_q && opcode_q == OPC_LOAD && rd_q != 5'd0 &&
                   ((rs1_used_s && rd_q == rs1_idx_s) || (rs2_used_s && rd_q == rs2_idx_s));
      ready_s    = !hazard_s && (!valid_q || i_ready) && !i_flush;
      hs_s       = i_valid && ready_s;
      accept_s   = hs_s && kill_q == 2'd0;
   end

   always_comb begin
      state_d = state_q;
      if (i_flush) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (accept_s && taken_s && KILL_SLOTS > 0) state_d = ST_KILL;
               else if (hazard_s) state_d = ST_STALL;
               else state_d = ST_RUN;
            end
            ST_KILL: begin
               if (hs_s && kill_q <= 2'd1) state_d = ST_RUN;
               else state_d = ST_KILL;
            end
            ST_STALL: begin
               if (hazard_s) state_d = ST_STALL;
               else if (accept_s && taken_s && KILL_SLOTS > 0) state_d = ST_KILL;
               else state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NREG; k++) rf_q[k] <= '0;
      end else if (i_wr && i_rd != 5'd0 && {1'b0, i_rd} < NREG_L) begin
         rf_q[i_rd[AW-1:0]] <= i_write_data;
      end else begin
         rf_q <= rf_q;
      end
   end

   // Flush outranks accept, redirect and stall; a killed handshake never reaches ID/EX.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         valid_q       <= 1'b0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         imm_q         <= '0;
         pc_q          <= '0;
         opcode_q      <= 7'd0;
         func3_q       <= 3'd0;
         rd_q          <= 5'd0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         stall_q       <= 16'd0;
         kill_q        <= 2'd0;
      end else begin
         state_q <= state_d;
         if (i_flush) begin
            valid_q <= 1'b0;
         end else if (accept_s) begin
            valid_q  <= 1'b1;
            rs1_q    <= rs1_s;
            rs2_q    <= rs2_s;
            imm_q    <= imm_s;
            pc_q     <= i_pc;
            opcode_q <= opc_s;
            func3_q  <= f3_s;
            rd_q     <= i_instr[11:7];
         end else if (!valid_q || i_ready) begin
            valid_q <= 1'b0;
         end
         redirect_q <= accept_s && taken_s;
         if (accept_s && taken_s) redirect_pc_q <= target_s;
         if (i_flush) kill_q <= 2'd0;
         else if (accept_s && taken_s) kill_q <= KILL_L;
         else if (hs_s && kill_q != 2'd0) kill_q <= kill_q - 2'd1;
         if (hazard_s && !i_flush && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      end
   end

   assign o_ready       = ready_s;
   assign o_valid       = valid_q;
   assign o_rs1_data    = rs1_q;
   assign o_rs2_data    = rs2_q;
   assign o_imm_data    = imm_q;
   assign o_opcode      = opcode_q;
   assign o_func3       = func3_q;
   assign o_rd          = rd_q;
   assign o_pc          = pc_q;
   assign o_redirect    = redirect_q;
   assign o_redirect_pc = redirect_pc_q;
   assign o_stall_cnt   = stall_q;
endmodule

// File: doc/decode_stage_p.md
DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and PC width (32 or 64).
REQ-002 SHALL have parameter NREG, default 32, meaning register count (16 for RV32E or 32); index width is 5.
REQ-003 SHALL have parameter BYPASS, default 1, meaning WB-to-read write-first forwarding is enabled.
REQ-004 SHALL have parameter KILL_SLOTS, default 1, meaning wrong-path input handshakes dropped after a redirect (0..3).
REQ-005 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  fetch has an instruction.
- o_ready  out  1  stage accepts an instruction.
- i_instr  in  32  instruction.
- i_pc  in  XLEN  instruction PC.
- i_wr  in  1  WB write enable.
- i_rd  in  5  WB destination.
- i_write_data  in  XLEN  WB data.
- i_flush  in  1  downstream flush.
- o_valid  out  1  ID/EX register holds a valid instruction.
- i_ready  in  1  EX accepts.
- o_rs1_data, o_rs2_data, o_imm_data  out  XLEN  operands and sign-extended immediate.
- o_opcode  out  7  opcode.
- o_func3  out  3  func3.
- o_rd  out  5  destination register.
- o_pc  out  XLEN  instruction PC.
- o_redirect  out  1  one-cycle redirect pulse to fetch.
- o_redirect_pc  out  XLEN  redirect target.
- o_stall_cnt  out  16  load-use stall cycles.

Function
REQ-006 SHALL transfer an input instruction only when i_valid && o_ready, and an output instruction only when o_valid && i_ready.
REQ-007 SHALL drive o_ready = !hazard && (!o_valid || i_ready) && !i_flush.
REQ-008 SHALL assert hazard when all of the following hold: o_valid; o_opcode == LOAD (0000011); o_rd != 0; o_rd matches an rs1 or rs2 that the incoming instruction reads.
REQ-009 SHALL treat rs1 as unused for LUI, AUIPC and JAL, and rs2 as used only for R, S and B types.
REQ-010 SHALL, on a hazard cycle with i_ready=1, clear o_valid at the next edge so that one bubble is inserted.
REQ-011 SHALL hold all ID/EX outputs unchanged while o_valid && !i_ready, with no flush.
REQ-012 SHALL hold NREG x XLEN registers with x0 reading zero; a write at the clock edge occurs when i_wr && i_rd != 0 && i_rd < NREG.
REQ-013 SHALL, with BYPASS=1, return i_write_data on a read whose index equals i_rd while i_wr is high and i_rd != 0; with BYPASS=0 the read returns the old value.
REQ-014 SHALL generate the immediate for I, S, B, U and J formats, sign-extended to XLEN; it SHALL be 0 for R-type.
REQ-015 SHALL resolve branches on an accepted instruction using bypassed operands:
- BEQ, BNE, BLT, BGE, BLTU, BGEU are taken to pc+imm.
- JAL is taken to pc+imm.
- JALR is taken to (rs1+imm) & ~1.
REQ-016 SHALL register o_redirect=1 and o_redirect_pc for exactly one cycle after accepting a taken instruction; the taken instruction itself still enters the ID/EX register.
REQ-017 SHALL load a kill counter with KILL_SLOTS on a redirect; each subsequent input handshake is consumed and discarded while the counter > 0, and decrements the counter.
REQ-018 SHALL implement the states RUN, KILL and STALL:
- RUN->KILL on redirect (when KILL_SLOTS > 0).
- KILL->RUN when the counter reaches 0.
- RUN->STALL on hazard.
- STALL->RUN when the hazard clears.
REQ-019 SHALL, on i_flush, clear o_valid and the kill counter and return to RUN at the next edge; i_flush SHALL take precedence over accept, redirect and stall.
REQ-020 SHALL increment o_stall_cnt on each hazard cycle, saturating at 16'hFFFF.
REQ-021 SHALL give a simultaneous WB write and hazard to the same register no effect on hazard, i.e. the stall still occurs.

Reset
REQ-022 SHALL, on a clock edge with rst_n=0, set the following to 0 and the state to RUN: o_valid, o_redirect, o_redirect_pc, o_stall_cnt, the kill counter, all registers, and all ID/EX data outputs.
REQ-023 SHALL, on reset mid-operation, discard any in-flight or killed instruction; o_ready SHALL be 1 on the first cycle after rst_n rises.

Verification
REQ-024 SHALL cover: WB writes x5=0x1234 in the same cycle that ADD x6,x5,x0 is accepted -> o_rs1_data=0x1234 with BYPASS=1, or 0 with BYPASS=0.
REQ-025 SHALL cover: LW x7 sits in ID/EX, ADDI x8,x7,1 is presented, i_ready=1 -> o_ready=0 for one cycle, one bubble, o_stall_cnt=1.
REQ-026 SHALL cover: BEQ x0,x0,+16 at pc=0x100 is accepted -> o_redirect=1, o_redirect_pc=0x110, the next accepted input is dropped, and the one after that reaches o_valid.
REQ-027 SHALL cover: JALR with x1=0x203 and imm=0 -> o_redirect_pc=0x202.
REQ-028 SHALL cover: o_valid=1, i_ready=0 for 3 cycles -> outputs are stable; then i_flush=1 -> o_valid=0 at the next edge.
REQ-029 SHALL cover: a write to x0 followed by a read -> 0; o_stall_cnt forced to 0xFFFF plus one hazard -> remains 0xFFFF.
